// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: port IDs, default
// geometry, and the read-return tag carried alongside the memory pipeline.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4096;

    // Port IDs; also the encoding of last_gnt and of the tag's port field.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Stage-2 tag: one entry per read in flight.
    typedef struct packed {
        logic valid;  // a read response is due this cycle
        logic port;   // originating port (PORT_IF / PORT_D)
        logic oor;    // address was out of range: return 0
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. On a tie the port that was not granted
// last wins; a sole requester always wins. last_gnt only moves when a grant
// is actually taken (advance).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (last_gnt -> PORT_IF)
//   req[1:0]    requests, bit 0 = fetch, bit 1 = data
//   advance     a grant is taken this cycle
//   gnt[1:0]    one-hot (or zero) combinational grant
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_gnt_q, last_gnt_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_gnt_q == PORT_D) ? 2'b01 : 2'b10;
        end
        last_gnt_d = last_gnt_q;
        if (advance) begin
            last_gnt_d = gnt[1];  // gnt[1] set means PORT_D won
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= PORT_IF;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Front end for a single-port synchronous memory shared by instruction fetch
// (port 0, read-only) and load/store (port 1). One access is granted per
// cycle, registered into a command stage (mem_*), and reads are tracked by a
// tag stage so that data returns to its port exactly 2 cycles after grant.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   if_req/if_addr/if_gnt              fetch request / address / accept
//   if_rvalid/if_rdata                 fetch read return
//   d_req/d_we/d_addr/d_wdata/d_gnt    data request / accept
//   d_rvalid/d_rdata/d_err             load return, out-of-range pulse
//   mem_addr/mem_din/mem_we/mem_re     registered memory command
//   mem_dout                           memory read data (cycle after mem_re)
//   busy                               any access in either pipeline stage
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam logic [ADDR_W:0] DepthW = DEPTH[ADDR_W:0];

    logic [1:0] req, gnt;
    logic       any_gnt;

    // Requests are masked during reset so nothing is accepted.
    assign req     = {d_req, if_req} & {2{rst_n}};
    assign any_gnt = |gnt;
    assign if_gnt  = gnt[0];
    assign d_gnt   = gnt[1];

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (any_gnt),
        .gnt     (gnt)
    );

    // Stage 1: command register plus the tag of the access it carries.
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              st_err_q, st_err_d;   // out-of-range store, reported at T+1
    logic              s1_busy_q, s1_busy_d;
    tag_t              tag1_q, tag1_d;
    // Stage 2: read tag aligned with mem_dout.
    tag_t              tag2_q, tag2_d;

    logic [ADDR_W-1:0] win_addr;
    logic              win_oor;
    logic              win_read;

    always_comb begin
        win_addr = gnt[1] ? d_addr : if_addr;
        win_oor  = ({1'b0, win_addr} >= DepthW);
        win_read = gnt[0] | ~d_we;

        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        st_err_d     = 1'b0;
        s1_busy_d    = any_gnt;
        tag1_d       = '0;

        if (any_gnt) begin
            mem_addr_d   = win_addr;
            mem_din_d    = gnt[1] ? d_wdata : '0;
            mem_we_d     = gnt[1] & d_we & ~win_oor;
            mem_re_d     = win_read & ~win_oor;
            st_err_d     = gnt[1] & d_we & win_oor;
            tag1_d.valid = win_read;
            tag1_d.port  = gnt[1];
            tag1_d.oor   = win_oor;
        end

        tag2_d = tag1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            st_err_q   <= 1'b0;
            s1_busy_q  <= 1'b0;
            tag1_q     <= '0;
            tag2_q     <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            st_err_q   <= st_err_d;
            s1_busy_q  <= s1_busy_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign mem_re   = mem_re_q;

    // Read return: out-of-range reads never touched the memory, so force 0.
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        resp_data = tag2_q.oor ? '0 : mem_dout;
        if_rvalid = tag2_q.valid & (tag2_q.port == PORT_IF);
        d_rvalid  = tag2_q.valid & (tag2_q.port == PORT_D);
        if_rdata  = if_rvalid ? resp_data : '0;
        d_rdata   = d_rvalid ? resp_data : '0;
        d_err     = st_err_q | (d_rvalid & tag2_q.oor);
        busy      = s1_busy_q | tag2_q.valid;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_dout;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_dout  (mem_dout),
        .busy      (busy)
    );

    // Synchronous 4096 x 32 memory model.
    logic [31:0] mem [0:4095];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:0]] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_addr[11:0]];
    end

    typedef struct {
        logic        rst;
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [31:0] wd;
        logic [1:0]  g;     // {d_gnt, if_gnt}
        logic        re;
        logic        we;
        logic        irv;
        logic [31:0] ird;
        logic        drv;
        logic [31:0] drd;
        logic        err;
        logic        bsy;
    } vec_t;

    function automatic vec_t v(
        input logic rst, input logic ir, input logic [15:0] ia,
        input logic dr, input logic dw, input logic [15:0] da, input logic [31:0] wd,
        input logic [1:0] g, input logic re, input logic we,
        input logic irv, input logic [31:0] ird, input logic drv, input logic [31:0] drd,
        input logic err, input logic bsy);
        vec_t t;
        t.rst = rst; t.ir = ir; t.ia = ia; t.dr = dr; t.dw = dw; t.da = da; t.wd = wd;
        t.g = g; t.re = re; t.we = we; t.irv = irv; t.ird = ird; t.drv = drv; t.drd = drd;
        t.err = err; t.bsy = bsy;
        return t;
    endfunction

    task automatic chk1(input string name, input int cyc, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then let combinational grants settle.
    task automatic drive(input logic rst, input logic ir, input logic [15:0] ia,
                         input logic dr, input logic dw, input logic [15:0] da,
                         input logic [31:0] wd);
        @(negedge clk);
        rst_n = rst; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        // Preload
        mem[0]  <= 32'h0200_1400;
        mem[1]  <= 32'hA000_0001;
        mem[2]  <= 32'hA000_0002;
        mem[20] <= 32'h0000_0010;
        mem[21] <= 32'h0000_0011;
        mem[19] <= 32'h0000_0000;

        //            rst ir ia       dr dw da       wd            g     re we irv ird           drv drd    err bsy
        // reset, single fetch of address 0
        tbl.push_back(v(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));
        tbl.push_back(v(1, 1, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b01, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 1, 0, 0, 32'h0,         0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 1, 32'h0200_1400, 0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));
        // both ports contending: D, IF, D, IF, then fetch alone
        tbl.push_back(v(1, 1, 16'h0000, 1, 0, 16'd20,   32'h0, 2'b10, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));
        tbl.push_back(v(1, 1, 16'h0000, 1, 0, 16'd21,   32'h0, 2'b01, 1, 0, 0, 32'h0,         0, 32'h0,  0, 1));
        tbl.push_back(v(1, 1, 16'h0001, 1, 0, 16'd21,   32'h0, 2'b10, 1, 0, 0, 32'h0,         1, 32'h10, 0, 1));
        tbl.push_back(v(1, 1, 16'h0001, 0, 0, 16'd0,    32'h0, 2'b01, 1, 0, 1, 32'h0200_1400, 0, 32'h0,  0, 1));
        tbl.push_back(v(1, 1, 16'h0002, 0, 0, 16'd0,    32'h0, 2'b01, 1, 0, 0, 32'h0,         1, 32'h11, 0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'd0,    32'h0, 2'b00, 1, 0, 1, 32'hA000_0001, 0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'd0,    32'h0, 2'b00, 0, 0, 1, 32'hA000_0002, 0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'd0,    32'h0, 2'b00, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));
        // store 1 to 19, then load 19 in the next cycle
        tbl.push_back(v(1, 0, 16'h0000, 1, 1, 16'd19,   32'h1, 2'b10, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));
        tbl.push_back(v(1, 0, 16'h0000, 1, 0, 16'd19,   32'h0, 2'b10, 0, 1, 0, 32'h0,         0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'd0,    32'h0, 2'b00, 1, 0, 0, 32'h0,         0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'd0,    32'h0, 2'b00, 0, 0, 0, 32'h0,         1, 32'h1,  0, 1));
        // out-of-range load, then out-of-range store
        tbl.push_back(v(1, 0, 16'h0000, 1, 0, 16'h1000, 32'h0, 2'b10, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 0, 32'h0,         0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 0, 32'h0,         1, 32'h0,  1, 1));
        tbl.push_back(v(1, 0, 16'h0000, 1, 1, 16'h1000, 32'hDEADBEEF, 2'b10, 0, 0, 0, 32'h0,  0, 32'h0,  0, 0));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 0, 32'h0,         0, 32'h0,  1, 1));
        // out-of-range fetch: zero data, no error
        tbl.push_back(v(1, 1, 16'hF000, 0, 0, 16'h0000, 32'h0, 2'b01, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 0, 32'h0,         0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 1, 32'h0,         0, 32'h0,  0, 1));
        tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 32'h0, 2'b00, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0));

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].wd);
            chk1 ("if_gnt",    i, if_gnt,    tbl[i].g[0]);
            chk1 ("d_gnt",     i, d_gnt,     tbl[i].g[1]);
            chk1 ("mem_re",    i, mem_re,    tbl[i].re);
            chk1 ("mem_we",    i, mem_we,    tbl[i].we);
            chk1 ("if_rvalid", i, if_rvalid, tbl[i].irv);
            chk32("if_rdata",  i, if_rdata,  tbl[i].ird);
            chk1 ("d_rvalid",  i, d_rvalid,  tbl[i].drv);
            chk32("d_rdata",   i, d_rdata,   tbl[i].drd);
            chk1 ("d_err",     i, d_err,     tbl[i].err);
            chk1 ("busy",      i, busy,      tbl[i].bsy);
        end

        // Reset one cycle after a read grant drops the read; last_gnt returns to IF.
        drive(1, 0, 16'h0, 1, 0, 16'd20, 32'h0);
        chk1("rst_seq d_gnt", 100, d_gnt, 1'b1);
        drive(0, 1, 16'h3, 1, 0, 16'd21, 32'h0);
        chk1("rst_seq if_gnt in reset", 101, if_gnt, 1'b0);
        chk1("rst_seq d_gnt in reset", 101, d_gnt, 1'b0);
        drive(1, 0, 16'h0, 0, 0, 16'd0, 32'h0);
        chk1("rst_seq d_rvalid", 102, d_rvalid, 1'b0);
        chk1("rst_seq if_rvalid", 102, if_rvalid, 1'b0);
        chk1("rst_seq busy", 102, busy, 1'b0);
        chk1("rst_seq mem_re", 102, mem_re, 1'b0);
        chk32("rst_seq mem_addr", 102, {16'h0, mem_addr}, 32'h0);
        drive(1, 1, 16'h3, 1, 0, 16'd21, 32'h0);
        chk1("rst_seq tie d_gnt", 103, d_gnt, 1'b1);
        chk1("rst_seq tie if_gnt", 103, if_gnt, 1'b0);
        drive(1, 0, 16'h0, 0, 0, 16'd0, 32'h0);
        drive(1, 0, 16'h0, 0, 0, 16'd0, 32'h0);
        chk1("rst_seq d_rvalid after", 105, d_rvalid, 1'b1);
        chk32("rst_seq d_rdata after", 105, d_rdata, 32'h11);

        // Fetch alone for 5 cycles, then the data port wins the first tie.
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 16'(k), 0, 0, 16'd0, 32'h0);
            chk1("fetch_run if_gnt", 200 + k, if_gnt, 1'b1);
        end
        drive(1, 1, 16'h5, 1, 0, 16'd20, 32'h0);
        chk1("fetch_run d_gnt", 205, d_gnt, 1'b1);
        chk1("fetch_run if_gnt", 205, if_gnt, 1'b0);
        drive(1, 1, 16'h5, 0, 0, 16'd0, 32'h0);
        chk1("fetch_run if_gnt after", 206, if_gnt, 1'b1);
        drive(1, 0, 16'h0, 0, 0, 16'd0, 32'h0);
        chk1("fetch_run d_rvalid", 207, d_rvalid, 1'b1);
        chk32("fetch_run d_rdata", 207, d_rdata, 32'h10);
        drive(1, 0, 16'h0, 0, 0, 16'd0, 32'h0);
        drive(1, 0, 16'h0, 0, 0, 16'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port front end for the single-port 4096 x 32 unified memory. Arbitrates, cycle by cycle, between the instruction-fetch port (port 0) and the load/store data port (port 1). Issues one registered read or write per cycle to the memory, and returns read data to the originating port with a fixed latency. Sits between the CPU control/datapath and the memory instance.

## Interface
Parameters:
- ADDR_W, 16: address width on all ports.
- DATA_W, 32: data width.
- DEPTH, 4096: implemented words. Addresses >= DEPTH are out of range.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address. Fetch is read-only.
- if_gnt  out  1  combinational accept for the current cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held, with its command stable, until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  combinational accept.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- d_err  out  1  one-cycle pulse: out-of-range data access.
- mem_addr  out  ADDR_W  registered memory address.
- mem_din  out  DATA_W  registered write data.
- mem_we  out  1  registered write enable.
- mem_re  out  1  registered read enable.
- mem_dout  in  DATA_W  memory read data; valid the cycle after mem_re.
- busy  out  1  high while any access is in the 2-stage pipeline.

## Operation
- At most one grant per cycle. A requester is granted in the cycle its req is high and it wins arbitration.
- Arbitration is 2-way round-robin:
  - last_gnt (1 bit) records the last granted port.
  - On a tie, the port not equal to last_gnt wins.
  - A sole requester always wins.
  - last_gnt updates only on a grant.
- Stage 1 (command register), loaded on grant:
  - mem_addr and mem_din take the winner's address and data.
  - mem_we = winner is data port AND d_we AND address in range.
  - mem_re = winner's access is a read AND address in range.
  - With no grant, mem_we and mem_re are 0. mem_addr and mem_din hold their values.
- Stage 2 (tag register) holds {valid, port, oor}. It follows stage 1 by one cycle for reads only.
- Read return:
  - When the stage-2 tag is valid, pulse the matching *_rvalid.
  - Its rdata = mem_dout if in range, else 0.
  - Non-selected rdata outputs are 0.
- Out of range means addr >= DEPTH, i.e. any of bits [15:12] set.
  - Writes are suppressed. Reads return 0 with rvalid.
  - Data-port accesses pulse d_err together with the response; for a store, that is the cycle after grant.
  - Fetch out of range: return 0 with if_rvalid. There is no error output for fetch.
- Stores produce no rvalid.

## Timing
- Grant in cycle T. mem_we/mem_re asserted in T+1. Read data and *_rvalid in T+2.
- Latency is fixed at 2 cycles from grant. Throughput is 1 access per cycle.
- Back-to-back reads from alternating ports return in grant order.
- Store in T followed by a load of the same address in T+1: the load returns the new data. The memory is written at the end of T+1 and read at the end of T+2.
- Reset (rst_n = 0 at an edge) sets:
  - all pipeline valids, mem_we, mem_re, *_rvalid, d_err and busy to 0;
  - mem_addr and mem_din to 0;
  - last_gnt to port 0, so the data port wins the first tie.
- Accesses in flight when reset asserts are dropped; no rvalid is produced for them.
- gnt is 0 while rst_n = 0.

## Structure
- Package mem_arb_pkg holds:
  - the port ID constants PORT_IF = 0 and PORT_D = 1;
  - the DEPTH and ADDR_W defaults;
  - the stage-2 tag struct {valid, port, oor}.
- Sub-module rr_arb2: 2-requester round-robin with last_gnt state. Inputs req[1:0] and advance; output gnt[1:0].
- Everything else (stage registers, return muxing) lives in mem_arbiter.

## Test plan
- Reset, then a single fetch of address 0 in a memory preloaded with 0x02001400 at address 0: if_gnt in the same cycle, mem_re in T+1, if_rvalid with if_rdata = 0x02001400 in T+2.
- Both ports request continuously after reset (fetch addresses 0, 1, 2; data loads of 20, 21 holding 0x10 and 0x11): grants go D, IF, D, IF, ... and each rvalid carries the correct word 2 cycles after its grant.
- Store 0x00000001 to address 19 in T, load address 19 in T+1: d_rvalid in T+3 with d_rdata = 0x00000001.
- Data load of address 0x1000: no mem_re, d_rvalid with d_rdata = 0 and d_err pulse in T+2. A store to 0x1000 leaves mem_we at 0 and pulses d_err in T+1.
- Reset asserted one cycle after a read grant: no rvalid is produced, busy = 0, and the next tie after reset is granted to the data port.
- Fetch alone for 5 cycles, then d_req asserted: data is granted on the first cycle it requests, because last_gnt = IF.
